// File: rtl/sent_tx_crc_sched_if.sv
// rtl/sent_tx_crc_sched_if.sv - request/response bundle between SENT builders and the shared CRC engine
//
// Purpose: groups the fast-channel and slow-channel CRC request/ack signals
//          and the engine busy flag into one port.
// Signals:
//   fast_req / fast_mode[1:0] / fast_data[23:0]  fast-channel request, nibble count, data
//   fast_ack / fast_crc[3:0]                     fast completion pulse and held CRC4
//   slow_req / slow_mode / slow_data[23:0]       slow-channel request, short/enhanced, data
//   slow_ack / slow_crc[5:0]                     slow completion pulse and held CRC
//   busy                                         engine occupied (shift and done phases)
// Modports: master = requester side, slave = CRC engine side.

interface sent_tx_crc_sched_if;
  logic        fast_req;
  logic [1:0]  fast_mode;
  logic [23:0] fast_data;
  logic        fast_ack;
  logic [3:0]  fast_crc;
  logic        slow_req;
  logic        slow_mode;
  logic [23:0] slow_data;
  logic        slow_ack;
  logic [5:0]  slow_crc;
  logic        busy;

  modport master (
    output fast_req, fast_mode, fast_data,
    output slow_req, slow_mode, slow_data,
    input  fast_ack, fast_crc, slow_ack, slow_crc, busy
  );

  modport slave (
    input  fast_req, fast_mode, fast_data,
    input  slow_req, slow_mode, slow_data,
    output fast_ack, fast_crc, slow_ack, slow_crc, busy
  );
endinterface

// File: rtl/sent_tx_crc_sched.sv
// rtl/sent_tx_crc_sched.sv - shared bit-serial CRC4/CRC6 engine with two-requester arbiter
//
// Purpose: one shift-register CRC datapath shared by the SENT fast channel
//          (CRC4 over 3/4/6 nibbles) and slow channel (short CRC4, enhanced CRC6).
//          The message {seed, data, W zeros} is shifted in MSB first, one bit
//          per clock; the remainder is latched into the owner's CRC register.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      sent_tx_crc_sched_if.slave (requests in, acks/CRCs/busy out)

module sent_tx_crc_sched #(
  parameter logic [4:0] POLY4 = 5'b11101,
  parameter logic [3:0] SEED4 = 4'b0101,
  parameter logic [6:0] POLY6 = 7'b1011001,
  parameter logic [5:0] SEED6 = 6'b010101,
  parameter bit         RR_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sent_tx_crc_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [35:0] msg_q;        // left-aligned message, MSB is the next bit in
  logic [5:0]  cnt_q;        // bits still to shift
  logic [5:0]  r_q;          // running remainder
  logic        owner_q;      // 0 = fast, 1 = slow
  logic        wide_q;       // 1 = CRC6 job
  logic        pref_slow_q;  // round-robin pointer: slow wins the next tie
  logic [3:0]  fast_crc_q;
  logic [5:0]  slow_crc_q;

  logic        any_req;
  logic        grant_slow;
  logic [35:0] load_msg;
  logic [5:0]  load_cnt;
  logic        load_wide;
  logic [5:0]  r_next;

  // Arbitration, only meaningful while idle.
  always_comb begin
    any_req = bus.fast_req | bus.slow_req;
    if (bus.fast_req && bus.slow_req) begin
      grant_slow = RR_EN && pref_slow_q;
    end else begin
      grant_slow = bus.slow_req;
    end
  end

  // Message image and bit count for the granted job. The trailing zeros
  // below the data include the W appended zero bits of the division.
  always_comb begin
    load_msg  = '0;
    load_cnt  = '0;
    load_wide = 1'b0;
    if (grant_slow) begin
      if (bus.slow_mode) begin
        load_msg  = {SEED6, bus.slow_data, 6'b0};
        load_cnt  = 6'd36;
        load_wide = 1'b1;
      end else begin
        load_msg = {SEED4, bus.slow_data[7:0], 24'b0};
        load_cnt = 6'd16;
      end
    end else begin
      case (bus.fast_mode)
        2'd0: begin
          load_msg = {SEED4, bus.fast_data[11:0], 20'b0};
          load_cnt = 6'd20;
        end
        2'd1: begin
          load_msg = {SEED4, bus.fast_data[15:0], 16'b0};
          load_cnt = 6'd24;
        end
        default: begin
          load_msg = {SEED4, bus.fast_data[23:0], 8'b0};
          load_cnt = 6'd32;
        end
      endcase
    end
  end

  // One division step. For CRC4 jobs the upper two remainder bits stay zero,
  // which is also what the slow CRC register reports for short messages.
  always_comb begin
    if (wide_q) begin
      r_next = {r_q[4:0], msg_q[35]} ^ (r_q[5] ? POLY6[5:0] : 6'd0);
    end else begin
      r_next = {2'b00, r_q[2:0], msg_q[35]} ^ (r_q[3] ? {2'b00, POLY4[3:0]} : 6'd0);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == 6'd1) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. busy covers shift and done; the idle cycle in which the
  // next grant is decided shows busy low, so back-to-back jobs leave a
  // single low cycle between them.
  always_comb begin
    bus.fast_ack = 1'b0;
    bus.slow_ack = 1'b0;
    bus.busy     = (state_q != ST_IDLE);
    if (state_q == ST_DONE) begin
      bus.fast_ack = ~owner_q;
      bus.slow_ack = owner_q;
    end
  end

  assign bus.fast_crc = fast_crc_q;
  assign bus.slow_crc = slow_crc_q;

  // Datapath. The result register is written on the edge that enters DONE,
  // so the new CRC is already visible during the ack cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_q       <= '0;
      cnt_q       <= '0;
      r_q         <= '0;
      owner_q     <= 1'b0;
      wide_q      <= 1'b0;
      pref_slow_q <= 1'b0;
      fast_crc_q  <= '0;
      slow_crc_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            msg_q       <= load_msg;
            cnt_q       <= load_cnt;
            r_q         <= '0;
            owner_q     <= grant_slow;
            wide_q      <= load_wide;
            pref_slow_q <= ~grant_slow;
          end
        end
        ST_SHIFT: begin
          msg_q <= {msg_q[34:0], 1'b0};
          cnt_q <= cnt_q - 6'd1;
          r_q   <= r_next;
          if (cnt_q == 6'd1) begin
            if (owner_q) begin
              slow_crc_q <= r_next;
            end else begin
              fast_crc_q <= r_next[3:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sent_tx_crc_sched.sv
// tb/tb_sent_tx_crc_sched.sv - scoreboard bench for the shared SENT CRC engine
//
// Purpose: drives directed and randomised CRC jobs into two engine instances
//          (round-robin and fixed-priority); a monitor checks owner, CRC,
//          latency and the untouched other-channel CRC on every ack.

module tb_sent_tx_crc_sched;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sent_tx_crc_sched_if bus ();
  sent_tx_crc_sched_if bus0 ();

  sent_tx_crc_sched #(.RR_EN(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  sent_tx_crc_sched #(.RR_EN(1'b0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  typedef struct {
    bit         slow;
    logic [5:0] crc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain polynomial long division of {seed, data, W zeros}.
  function automatic logic [5:0] model(input bit slow, input logic [1:0] mode, input logic [23:0] data);
    logic [47:0] m;
    logic [47:0] p;
    int          w;
    int          dbits;
    int          len;
    bit          wide;
    wide  = slow && mode[0];
    w     = wide ? 6 : 4;
    dbits = slow ? (wide ? 24 : 8) : (mode == 2'd0 ? 12 : (mode == 2'd1 ? 16 : 24));
    m     = wide ? 48'h15 : 48'h5;
    m     = (m << dbits) | ({24'b0, data} & ((48'd1 << dbits) - 48'd1));
    m     = m << w;
    len   = w + dbits + w;
    p     = wide ? 48'h59 : 48'h1D;
    for (int i = len - 1; i >= w; i--) begin
      if (m[i]) m = m ^ (p << (i - w));
    end
    return wide ? m[5:0] : {2'b00, m[3:0]};
  endfunction

  function automatic int nbits(input bit slow, input logic [1:0] mode);
    if (slow) return mode[0] ? 36 : 16;
    return (mode == 2'd0) ? 20 : ((mode == 2'd1) ? 24 : 32);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit slow, input logic [1:0] mode, input logic [5:0] crc);
    exp_t e;
    e.slow = slow;
    e.crc  = crc;
    e.lat  = nbits(slow, mode) + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input bit slow, input bit scramble);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick;
      if (scramble && i == 0) begin
        if (slow) bus.slow_data = ~bus.slow_data;
        else      bus.fast_data = ~bus.fast_data;
      end
      if ((slow && bus.slow_ack) || (!slow && bus.fast_ack)) begin
        got = 1'b1;
        break;
      end
    end
    if (slow) begin
      chk("slow_ack_seen", got, 1);
      bus.slow_req = 1'b0;
    end else begin
      chk("fast_ack_seen", got, 1);
      bus.fast_req = 1'b0;
    end
  endtask

  task automatic job(input bit slow, input logic [1:0] mode, input logic [23:0] data,
                     input logic [5:0] crc, input bit scramble);
    push_exp(slow, mode, crc);
    tick;
    if (slow) begin
      bus.slow_mode = mode[0];
      bus.slow_data = data;
      bus.slow_req  = 1'b1;
    end else begin
      bus.fast_mode = mode;
      bus.fast_data = data;
      bus.fast_req  = 1'b1;
    end
    wait_ack(slow, scramble);
  endtask

  // Monitor: pops one expectation per ack.
  initial begin
    int         rise_cyc;
    bit         prev_busy;
    logic [3:0] last_f;
    logic [5:0] last_s;
    exp_t       e;
    rise_cyc  = 0;
    prev_busy = 1'b0;
    last_f    = '0;
    last_s    = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_busy = 1'b0;
        last_f    = '0;
        last_s    = '0;
        continue;
      end
      if (bus.busy && !prev_busy) rise_cyc = cyc;
      if (bus.fast_ack || bus.slow_ack) begin
        chk("ack_onehot", {31'b0, bus.fast_ack & bus.slow_ack}, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: fast_ack=%0b slow_ack=%0b with no job outstanding",
                   bus.fast_ack, bus.slow_ack);
        end else begin
          e = exp_q.pop_front();
          chk("ack_owner", {31'b0, bus.slow_ack}, {31'b0, e.slow});
          chk("latency", cyc - rise_cyc + 1, e.lat);
          if (e.slow) begin
            chk("slow_crc", {26'b0, bus.slow_crc}, {26'b0, e.crc});
            chk("fast_crc_kept", {28'b0, bus.fast_crc}, {28'b0, last_f});
            last_s = e.crc;
          end else begin
            chk("fast_crc", {28'b0, bus.fast_crc}, {28'b0, e.crc[3:0]});
            chk("slow_crc_kept", {26'b0, bus.slow_crc}, {26'b0, last_s});
            last_f = e.crc[3:0];
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int         fast_acks;
    int         lows;
    int         fa;
    int         sa;
    bit         done;
    bit         rs;
    logic [1:0] rm;
    logic [23:0] rd;

    bus.fast_req = 1'b0;  bus.fast_mode = '0;  bus.fast_data = '0;
    bus.slow_req = 1'b0;  bus.slow_mode = 1'b0; bus.slow_data = '0;
    bus0.fast_req = 1'b0; bus0.fast_mode = '0; bus0.fast_data = '0;
    bus0.slow_req = 1'b0; bus0.slow_mode = 1'b0; bus0.slow_data = '0;

    reset_n = 1'b0;
    repeat (3) tick;
    chk("rst_fast_crc", {28'b0, bus.fast_crc}, 0);
    chk("rst_slow_crc", {26'b0, bus.slow_crc}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_acks", {30'b0, bus.fast_ack, bus.slow_ack}, 0);
    reset_n = 1'b1;

    // T1/T2: fast channel, all-zero data, hand-computed CRCs.
    job(1'b0, 2'd0, 24'h000000, 6'h09, 1'b0);
    job(1'b0, 2'd1, 24'h000000, 6'h0C, 1'b0);
    job(1'b0, 2'd2, 24'h000000, 6'h05, 1'b0);
    job(1'b0, 2'd3, 24'hABCDEF, model(1'b0, 2'd3, 24'hABCDEF), 1'b0);
    job(1'b0, 2'd0, 24'hFFF123, model(1'b0, 2'd0, 24'hFFF123), 1'b0);

    // T3: slow channel, short and enhanced.
    job(1'b1, 2'd1, 24'h0F00A5, model(1'b1, 2'd1, 24'h0F00A5), 1'b0);
    job(1'b1, 2'd0, 24'h0000A5, model(1'b1, 2'd0, 24'h0000A5), 1'b0);
    job(1'b1, 2'd0, 24'h000000, 6'h06, 1'b0);
    job(1'b1, 2'd1, 24'h000000, 6'h26, 1'b0);

    // T4: simultaneous requests after a slow grant -> fast, slow, fast.
    push_exp(1'b0, 2'd1, model(1'b0, 2'd1, 24'h001234));
    push_exp(1'b1, 2'd1, model(1'b1, 2'd1, 24'h0F0F0F));
    push_exp(1'b0, 2'd1, model(1'b0, 2'd1, 24'h001234));
    tick;
    bus.fast_mode = 2'd1; bus.fast_data = 24'h001234;
    bus.slow_mode = 1'b1; bus.slow_data = 24'h0F0F0F;
    bus.fast_req = 1'b1;  bus.slow_req = 1'b1;
    fast_acks = 0;
    lows = 0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (!bus.busy) lows++;
      if (bus.slow_ack) bus.slow_req = 1'b0;
      if (bus.fast_ack) begin
        fast_acks++;
        if (fast_acks == 2) begin
          bus.fast_req = 1'b0;
          done = 1'b1;
          break;
        end
      end
    end
    bus.fast_req = 1'b0;
    bus.slow_req = 1'b0;
    chk("t4_done", {31'b0, done}, 1);
    chk("t4_busy_gaps", lows, 2);

    // T5: data changed right after grant is ignored.
    job(1'b0, 2'd1, 24'h00BEEF, model(1'b0, 2'd1, 24'h00BEEF), 1'b1);
    job(1'b1, 2'd0, 24'h00003C, model(1'b1, 2'd0, 24'h00003C), 1'b1);

    // Fixed priority instance: slow starves while fast_req is held.
    tick;
    bus0.fast_mode = 2'd0; bus0.fast_data = 24'h0;
    bus0.slow_mode = 1'b0; bus0.slow_data = 24'h0;
    bus0.fast_req = 1'b1;  bus0.slow_req = 1'b1;
    fa = 0;
    sa = 0;
    for (int i = 0; i < 80; i++) begin
      tick;
      if (bus0.fast_ack) fa++;
      if (bus0.slow_ack) sa++;
    end
    chk("rr0_fast_served", {31'b0, fa >= 3}, 1);
    chk("rr0_slow_starved", sa, 0);
    chk("rr0_fast_crc", {28'b0, bus0.fast_crc}, 32'h9);
    bus0.fast_req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick;
      if (bus0.slow_ack) begin
        done = 1'b1;
        break;
      end
    end
    chk("rr0_slow_after_release", {31'b0, done}, 1);
    chk("rr0_slow_crc", {26'b0, bus0.slow_crc}, 32'h06);
    bus0.slow_req = 1'b0;

    // Random modes, data and idle gaps.
    for (int k = 0; k < 10; k++) begin
      rs = 1'($urandom_range(0, 1));
      rm = 2'($urandom_range(0, 3));
      rd = 24'($urandom);
      repeat ($urandom_range(0, 3)) tick;
      job(rs, rm, rd, model(rs, rm, rd), 1'b0);
    end

    // T6: reset in the middle of an enhanced job.
    tick;
    bus.slow_mode = 1'b1;
    bus.slow_data = 24'h123456;
    bus.slow_req  = 1'b1;
    repeat (20) tick;
    reset_n = 1'b0;
    #1;
    chk("t6_busy", {31'b0, bus.busy}, 0);
    chk("t6_acks", {30'b0, bus.fast_ack, bus.slow_ack}, 0);
    chk("t6_fast_crc", {28'b0, bus.fast_crc}, 0);
    chk("t6_slow_crc", {26'b0, bus.slow_crc}, 0);
    repeat (3) tick;
    push_exp(1'b1, 2'd1, model(1'b1, 2'd1, 24'h123456));
    reset_n = 1'b1;
    wait_ack(1'b1, 1'b0);

    repeat (5) tick;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
